// File: rtl/address_receiver_pkg.sv
// Shared definitions for the write-address link: default widths, beat-count macros and the receiver FSM states.
// ADDR_RX_GAP_HOLD_EN (used by address_receiver) selects hold-on-gap instead of abort-on-gap.
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 32
`endif
`ifndef BANDWIDTH_WRITE_ADDRESS
`define BANDWIDTH_WRITE_ADDRESS 8
`endif
`ifndef ADDR_RX_BEATS
`define ADDR_RX_BEATS(m, b) (((m) + (b) - 1) / (b))
`endif
`ifndef ADDR_RX_REM
`define ADDR_RX_REM(m, b) ((m) % (b))
`endif

package address_receiver_pkg;

  localparam int DEF_MEM_ADDR_SIZE = `MEM_ADDR_SIZE;
  localparam int DEF_BW_WRITE_ADDR = `BANDWIDTH_WRITE_ADDRESS;

  typedef enum logic {
    ADDR_RX_IDLE = 1'b0,
    ADDR_RX_RECV = 1'b1
  } addr_rx_state_e;

endpackage

// File: rtl/address_receiver_out_reg.sv
// One-entry valid/ready holding register for reassembled addresses; flags an overwrite of an unconsumed entry.
module addr_out_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_addr,
  input  logic         addr_ready,
  output logic [W-1:0] addr_out,
  output logic         addr_valid,
  output logic         overflow
);

  logic [W-1:0] addr_q, addr_d;
  logic         valid_q, valid_d;
  logic         overflow_q, overflow_d;

  always_comb begin
    addr_d     = addr_q;
    valid_d    = valid_q;
    overflow_d = 1'b0;
    // A completion always wins over the consumer's ready in the same cycle.
    if (load) begin
      addr_d     = load_addr;
      valid_d    = 1'b1;
      overflow_d = valid_q && !addr_ready;
    end else if (valid_q && addr_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      valid_q    <= valid_d;
      overflow_q <= overflow_d;
    end
  end

  assign addr_out   = addr_q;
  assign addr_valid = valid_q;
  assign overflow   = overflow_q;

endmodule

// File: rtl/address_receiver.sv
// Reassembles LSB-first address beats into a full address and hands it to addr_out_reg.
// Define ADDR_RX_GAP_HOLD_EN to hold a partial frame across send_addr gaps instead of aborting it.
module address_receiver
  import address_receiver_pkg::*;
#(
  parameter int MEM_ADDR_SIZE           = DEF_MEM_ADDR_SIZE,
  parameter int BANDWIDTH_WRITE_ADDRESS = DEF_BW_WRITE_ADDR
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [BANDWIDTH_WRITE_ADDRESS-1:0] addr_bus,
  input  logic                               send_addr,
  input  logic                               addr_ready,
  output logic [MEM_ADDR_SIZE-1:0]           addr_out,
  output logic                               addr_valid,
  output logic                               busy,
  output logic                               overflow,
  output logic                               frame_err
);

  localparam int BW    = BANDWIDTH_WRITE_ADDRESS;
  localparam int BEATS = `ADDR_RX_BEATS(MEM_ADDR_SIZE, BANDWIDTH_WRITE_ADDRESS);
  localparam int WIDE  = BEATS * BW;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  addr_rx_state_e           state_q, state_d;
  logic [CNT_W-1:0]         beat_cnt_q, beat_cnt_d;
  logic [MEM_ADDR_SIZE-1:0] shift_q, shift_d;
  logic [WIDE-1:0]          beat_ext;
  logic [MEM_ADDR_SIZE-1:0] assembled;
  logic                     complete;
  logic                     frame_err_d;

  // Place the beat at its slice in a frame-wide vector; bits past MEM_ADDR_SIZE drop off on truncation.
  always_comb begin
    beat_ext = '0;
    for (int b = 0; b < BEATS; b++) begin
      if (beat_cnt_q == CNT_W'(b)) beat_ext[b*BW +: BW] = addr_bus;
    end
  end

  assign assembled = shift_q | beat_ext[MEM_ADDR_SIZE-1:0];

  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    shift_d     = shift_q;
    complete    = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      ADDR_RX_IDLE: begin
        if (send_addr) begin
          shift_d = beat_ext[MEM_ADDR_SIZE-1:0];
          if (BEATS > 1) begin
            state_d    = ADDR_RX_RECV;
            beat_cnt_d = CNT_W'(1);
          end else begin
            complete = 1'b1;
          end
        end
      end
      ADDR_RX_RECV: begin
        if (send_addr) begin
          if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
            complete   = 1'b1;
            beat_cnt_d = '0;
            state_d    = ADDR_RX_IDLE;
          end else begin
            shift_d    = assembled;
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end else begin
`ifdef ADDR_RX_GAP_HOLD_EN
          state_d = ADDR_RX_RECV;
`else
          frame_err_d = 1'b1;
          beat_cnt_d  = '0;
          state_d     = ADDR_RX_IDLE;
`endif
        end
      end
      default: state_d = ADDR_RX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ADDR_RX_IDLE;
      beat_cnt_q <= '0;
      shift_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      shift_q    <= shift_d;
    end
  end

`ifdef ADDR_RX_GAP_HOLD_EN
  assign frame_err = 1'b0;
  logic unused_frame_err;
  assign unused_frame_err = frame_err_d;
`else
  logic frame_err_q;
  always_ff @(posedge clk) begin
    if (!reset) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_d;
  end
  assign frame_err = frame_err_q;
`endif

  assign busy = (state_q == ADDR_RX_RECV);

  addr_out_reg #(.W(MEM_ADDR_SIZE)) u_addr_out_reg (
    .clk        (clk),
    .reset      (reset),
    .load       (complete),
    .load_addr  (assembled),
    .addr_ready (addr_ready),
    .addr_out   (addr_out),
    .addr_valid (addr_valid),
    .overflow   (overflow)
  );

endmodule

// File: tb/tb_address_receiver.sv
// Bench for address_receiver: directed vector table, a 12-bit-beat instance, and random traffic against a frame-level model.
module tb_address_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  addr_bus;
  logic        send_addr;
  logic        addr_ready;
  logic [31:0] addr_out;
  logic        addr_valid, busy, overflow, frame_err;

  logic        reset12;
  logic [11:0] addr_bus12;
  logic        send_addr12;
  logic        addr_ready12;
  logic [31:0] addr_out12;
  logic        addr_valid12, busy12, overflow12, frame_err12;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  address_receiver #(.MEM_ADDR_SIZE(32), .BANDWIDTH_WRITE_ADDRESS(8)) dut (
    .clk(clk), .reset(reset), .addr_bus(addr_bus), .send_addr(send_addr),
    .addr_ready(addr_ready), .addr_out(addr_out), .addr_valid(addr_valid),
    .busy(busy), .overflow(overflow), .frame_err(frame_err)
  );

  address_receiver #(.MEM_ADDR_SIZE(32), .BANDWIDTH_WRITE_ADDRESS(12)) dut12 (
    .clk(clk), .reset(reset12), .addr_bus(addr_bus12), .send_addr(send_addr12),
    .addr_ready(addr_ready12), .addr_out(addr_out12), .addr_valid(addr_valid12),
    .busy(busy12), .overflow(overflow12), .frame_err(frame_err12)
  );

  typedef struct {
    bit          rst_n;
    bit          send;
    logic [7:0]  bus;
    bit          ready;
    bit          exp_valid;
    logic [31:0] exp_out;
    bit          exp_busy;
    bit          exp_ovf;
    bit          exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit s, logic [7:0] b, bit rdy,
                              bit v, logic [31:0] o, bit bz, bit ov, bit er);
    vec_t t;
    t.rst_n = r; t.send = s; t.bus = b; t.ready = rdy;
    t.exp_valid = v; t.exp_out = o; t.exp_busy = bz; t.exp_ovf = ov; t.exp_err = er;
    return t;
  endfunction

  task automatic check(string name, logic [35:0] act, logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got v=%b busy=%b ovf=%b err=%b out=%h, want v=%b busy=%b ovf=%b err=%b out=%h",
               name, act[35], act[34], act[33], act[32], act[31:0],
               exp[35], exp[34], exp[33], exp[32], exp[31:0]);
    end
  endtask

  // Frame-level reference: beats accumulate in a queue and are summed into an address when the frame is full.
  int unsigned m_beats[$];
  bit          m_valid, m_ovf, m_err;
  logic [31:0] m_out;

  task automatic model_step(bit r, bit s, logic [7:0] b, bit rdy);
    longint unsigned a;
    bit done;
    m_ovf = 0; m_err = 0; done = 0; a = 0;
    if (!r) begin
      m_beats.delete();
      m_valid = 0; m_out = '0;
      return;
    end
    if (s) begin
      m_beats.push_back(b);
      if (m_beats.size() == 4) begin
        for (int i = 0; i < 4; i++) a += longint'(m_beats[i]) * (64'd1 << (8 * i));
        m_beats.delete();
        done = 1;
      end
    end else if (m_beats.size() != 0) begin
`ifndef ADDR_RX_GAP_HOLD_EN
      m_beats.delete();
      m_err = 1;
`endif
    end
    if (done) begin
      m_ovf   = m_valid && !rdy;
      m_out   = a[31:0];
      m_valid = 1;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 0; addr_bus = '0; send_addr = 0; addr_ready = 0;
    reset12 = 0; addr_bus12 = '0; send_addr12 = 0; addr_ready12 = 0;

    // r, send, bus, ready -> valid, out, busy, ovf, err (values after the edge)
    vecs.push_back(mk(0, 0, 8'h00, 0, 0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h78, 1, 0, 32'h0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'h56, 1, 0, 32'h0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'h34, 1, 0, 32'h0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'h12, 1, 1, 32'h12345678, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 32'h12345678, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'hDD, 0, 0, 32'h12345678, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'hCC, 0, 0, 32'h12345678, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'hBB, 0, 0, 32'h12345678, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'hAA, 0, 1, 32'hAABBCCDD, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h44, 0, 1, 32'hAABBCCDD, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'h33, 0, 1, 32'hAABBCCDD, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'h22, 0, 1, 32'hAABBCCDD, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'h11, 0, 1, 32'h11223344, 0, 1, 0));
    vecs.push_back(mk(1, 0, 8'h00, 0, 1, 32'h11223344, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 32'h11223344, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h04, 0, 0, 32'h11223344, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'h03, 0, 0, 32'h11223344, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'h02, 0, 0, 32'h11223344, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'h01, 0, 1, 32'h01020304, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h88, 0, 1, 32'h01020304, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'h77, 0, 1, 32'h01020304, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'h66, 0, 1, 32'h01020304, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'h55, 1, 1, 32'h55667788, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 32'h55667788, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'h01, 1, 0, 32'h55667788, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'h02, 1, 0, 32'h55667788, 1, 0, 0));
`ifdef ADDR_RX_GAP_HOLD_EN
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 32'h55667788, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'h03, 1, 0, 32'h55667788, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'h04, 1, 1, 32'h04030201, 0, 0, 0));
`else
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 32'h55667788, 0, 0, 1));
    vecs.push_back(mk(1, 1, 8'h03, 1, 0, 32'h55667788, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'h04, 1, 0, 32'h55667788, 1, 0, 0));
`endif
    vecs.push_back(mk(0, 0, 8'h00, 1, 0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'hAA, 0, 0, 32'h0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'hBB, 0, 0, 32'h0, 1, 0, 0));
    vecs.push_back(mk(0, 1, 8'hCC, 0, 0, 32'h0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 8'hEF, 0, 0, 32'h0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'hBE, 0, 0, 32'h0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'hAD, 0, 0, 32'h0, 1, 0, 0));
    vecs.push_back(mk(1, 1, 8'hDE, 0, 1, 32'hDEADBEEF, 0, 0, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1, 0, 32'hDEADBEEF, 0, 0, 0));

    #2;
    foreach (vecs[i]) begin
      reset = vecs[i].rst_n; send_addr = vecs[i].send;
      addr_bus = vecs[i].bus; addr_ready = vecs[i].ready;
      tick();
      check($sformatf("vec%0d", i),
            {addr_valid, busy, overflow, frame_err, addr_out},
            {vecs[i].exp_valid, vecs[i].exp_busy, vecs[i].exp_ovf, vecs[i].exp_err, vecs[i].exp_out});
    end

    // 12-bit beats: three beats, upper nibble of the last one must be dropped.
    reset12 = 0; tick();
    check("bw12_reset", {addr_valid12, busy12, overflow12, frame_err12, addr_out12}, 36'h0);
    reset12 = 1; send_addr12 = 1; addr_ready12 = 0;
    addr_bus12 = 12'h678; tick();
    addr_bus12 = 12'h345; tick();
    check("bw12_mid", {addr_valid12, busy12, overflow12, frame_err12, addr_out12}, {4'b0100, 32'h0});
    addr_bus12 = 12'hF12; tick();
    send_addr12 = 0;
    check("bw12_done", {addr_valid12, busy12, overflow12, frame_err12, addr_out12}, {4'b1000, 32'h12345678});
    addr_ready12 = 1; tick();
    check("bw12_consumed", {addr_valid12, busy12, overflow12, frame_err12, addr_out12}, {4'b0000, 32'h12345678});

    // Random traffic against the frame-level model.
    reset = 0; send_addr = 0; addr_ready = 0; tick();
    model_step(0, 0, 8'h00, 0);
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 99) >= 2);
      send_addr  = ($urandom_range(0, 99) < 85);
      addr_bus   = 8'($urandom);
      addr_ready = ($urandom_range(0, 99) < 40);
      model_step(reset, send_addr, addr_bus, addr_ready);
      tick();
      check($sformatf("rand%0d", n),
            {addr_valid, busy, overflow, frame_err, addr_out},
            {m_valid, (m_beats.size() != 0), m_ovf, m_err, m_out});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/address_receiver.md
Name: address_receiver

Overview:
- Downstream partner of the address serializer on the write-address link.
- Samples narrow `addr_bus` beats qualified by `send_addr`, least-significant chunk first, and reassembles the full `MEM_ADDR_SIZE`-bit address.
- Presents the address to the memory/buffer side through a one-entry valid/ready output register.

Parameters:
- MEM_ADDR_SIZE, default `MEM_ADDR_SIZE (32): full address width.
- BANDWIDTH_WRITE_ADDRESS, default `BANDWIDTH_WRITE_ADDRESS (8): link beat width.
- BEATS, derived as ceil(MEM_ADDR_SIZE / BANDWIDTH_WRITE_ADDRESS): beats per address.
- REM, derived as MEM_ADDR_SIZE % BANDWIDTH_WRITE_ADDRESS: valid bits in the last beat; 0 means a full beat.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- addr_bus  in  BANDWIDTH_WRITE_ADDRESS  address beat from the sender.
- send_addr  in  1  beat valid; one beat is consumed per cycle while high.
- addr_ready  in  1  consumer accepts `addr_out` this cycle.
- addr_out  out  MEM_ADDR_SIZE  reassembled address; held while `addr_valid` is high.
- addr_valid  out  1  `addr_out` holds an unconsumed address.
- busy  out  1  a frame is partially received.
- overflow  out  1  one-cycle pulse: completed address overwrote an unconsumed one.
- frame_err  out  1  one-cycle pulse: partial frame discarded.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, beat_cnt=0, shift register=0.
  - addr_out=0, addr_valid=0, busy=0, overflow=0, frame_err=0.
  - Reset mid-frame discards the partial frame silently; no frame_err.
- FSM states: IDLE, RECV.
- IDLE:
  - send_addr=1: write beat 0 into bits [BW-1:0]; beat_cnt=1.
  - Go to RECV if BEATS>1; otherwise complete the frame immediately.
- RECV:
  - send_addr=1: write the beat into slice [beat_cnt*BW +: BW]; beat_cnt++.
  - On the beat where beat_cnt==BEATS-1: complete the frame, beat_cnt=0, go to IDLE.
- Last-beat width:
  - If REM!=0, only addr_bus[REM-1:0] of the final beat is used; upper bits are ignored.
  - No out-of-range slice writes are permitted.
- Back-to-back frames: `send_addr` high in the cycle after completion starts a new frame from IDLE with no bubble.
- Frame completion:
  - On the next clk edge, addr_out = assembled value and addr_valid=1.
  - Latency: addr_valid rises one cycle after the final beat is sampled.
- Output handshake:
  - addr_valid clears when addr_valid && addr_ready and no completion occurs in that cycle.
  - Completion and ready in the same cycle: new value loads, addr_valid stays 1, no overflow.
  - Completion while addr_valid=1 and addr_ready=0: new value overwrites, overflow pulses for 1 cycle.
- Gap (send_addr=0 in RECV), default behaviour:
  - Abort the frame: frame_err pulses 1 cycle, beat_cnt=0, go to IDLE.
  - addr_out and addr_valid are unaffected.
- busy = (state==RECV).
- addr_out is never modified by a partial frame.

Optional Feature:
- Macro: ADDR_RX_GAP_HOLD_EN.
- Defined:
  - A gap in RECV holds state and beat_cnt; reception resumes on the next send_addr=1.
  - frame_err is tied to 0.
- Undefined: gap aborts exactly as described in Behaviour.

Decomposition:
- Shared package/header (sys_defs):
  - `MEM_ADDR_SIZE`, `BANDWIDTH_WRITE_ADDRESS`.
  - Derived BEATS/REM macros, shared by the sender and this receiver.
  - State encoding localparams ADDR_RX_IDLE=1'b0, ADDR_RX_RECV=1'b1.
- One natural sub-module, `addr_out_reg`: the one-entry valid/ready holding register with overflow detection. The FSM and assembly logic stay in the top module.

Test Plan:
- MEM=32, BW=8; beats 0x78,0x56,0x34,0x12 on 4 consecutive cycles, addr_ready=1 → addr_out=0x12345678, addr_valid high for exactly 1 cycle, rising 1 cycle after the 4th beat.
- MEM=32, BW=12 (BEATS=3, REM=8); beats 0x678,0x345,0xF12 → addr_out=0x12345678, upper nibble of the last beat ignored.
- Two frames back-to-back (0xAABBCCDD then 0x11223344), addr_ready=0 → overflow pulses once; addr_out=0x11223344, addr_valid=1 until addr_ready=1.
- Completion in the same cycle as addr_ready=1 with a prior valid → addr_valid stays 1, overflow=0, addr_out updates.
- Beats 0x01,0x02, then send_addr=0 for 1 cycle, then 0x03,0x04:
  - Default → frame_err pulse, no addr_valid, busy=0 after the gap.
  - With ADDR_RX_GAP_HOLD_EN → addr_out=0x04030201.
- reset=0 after 2 of 4 beats, then a full frame 0xDEADBEEF → no frame_err, first addr_valid carries 0xDEADBEEF.
